// File: rtl/ipv4_ingress_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : ipv4_ingress_checker_if
//  Description : Handshake/data bundle between the header parser and the
//                ingress checker, and between the checker and the match stage.
//                master = producer of start/header (parser side)
//                slave  = ipv4_ingress_checker
//  Signals     : start_i, pkt_hdr_i, in_port_i        (parser -> checker)
//                ready_o, busy_o, pkt_hdr_o, in_port_o,
//                hdr_ok_o, drop_reason_o               (checker -> match)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ipv4_ingress_checker_if #(
  parameter int HDR_MAX_LEN = 64,
  parameter int NUM_PORTS   = 4
);
  logic                       start_i;
  logic [8*HDR_MAX_LEN-1:0]   pkt_hdr_i;
  logic [NUM_PORTS-1:0]       in_port_i;
  logic                       ready_o;
  logic                       busy_o;
  logic [8*HDR_MAX_LEN-1:0]   pkt_hdr_o;
  logic [NUM_PORTS-1:0]       in_port_o;
  logic                       hdr_ok_o;
  logic [2:0]                 drop_reason_o;

  modport master (
    output start_i, pkt_hdr_i, in_port_i,
    input  ready_o, busy_o, pkt_hdr_o, in_port_o, hdr_ok_o, drop_reason_o
  );

  modport slave (
    input  start_i, pkt_hdr_i, in_port_i,
    output ready_o, busy_o, pkt_hdr_o, in_port_o, hdr_ok_o, drop_reason_o
  );
endinterface
`default_nettype wire

// File: rtl/ipv4_ingress_checker.sv
`default_nettype none
// ============================================================================
//  Module      : ipv4_ingress_checker
//  Description : Validates a received Ethernet/IPv4 header before lookup:
//                EtherType, version/IHL, TTL and the IPv4 header checksum
//                (summed one 16-bit word per cycle). Header and ingress port
//                are passed through unchanged with a verdict and drop reason.
//  Ports       : clk, rst (sync, active-high)
//                bus.start_i/pkt_hdr_i/in_port_i : header request (sampled
//                                                   only when idle)
//                bus.ready_o  : verdict valid level, held until next accept
//                bus.busy_o   : high while a header is being checked
//                bus.pkt_hdr_o/in_port_o : latched copies of the request
//                bus.hdr_ok_o/drop_reason_o : verdict
//                  (0 OK, 1 NOT_IPV4, 2 BAD_VER_IHL, 3 TTL_EXPIRED,
//                   4 BAD_CKSUM)
//  Revision    : 1.0 - initial release
// ============================================================================
module ipv4_ingress_checker #(
  parameter int HDR_MAX_LEN = 64,
  parameter int IP_OFFSET   = 14,
  parameter int NUM_PORTS   = 4
) (
  input  wire                        clk,
  input  wire                        rst,
  ipv4_ingress_checker_if.slave      bus
);

  localparam logic [1:0] S_FREE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_SUM   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] c_RSN_OK        = 3'd0;
  localparam logic [2:0] c_RSN_NOT_IPV4  = 3'd1;
  localparam logic [2:0] c_RSN_BAD_VIHL  = 3'd2;
  localparam logic [2:0] c_RSN_TTL       = 3'd3;
  localparam logic [2:0] c_RSN_BAD_CKSUM = 3'd4;

  localparam int         c_NUM_WORDS     = 10;
  localparam logic [3:0] c_LAST_IDX      = 4'd9;

  logic [1:0]                r_state;
  logic [19:0]               r_acc;
  logic [3:0]                r_idx;
  logic                      r_ready;
  logic                      r_hdr_ok;
  logic [2:0]                r_reason;
  logic [8*HDR_MAX_LEN-1:0]  r_hdr;
  logic [NUM_PORTS-1:0]      r_port;

  logic [15:0] w_ethertype;
  logic [7:0]  w_ver_ihl;
  logic [7:0]  w_ttl;
  logic [15:0] w_words [c_NUM_WORDS];
  logic [15:0] w_word;
  logic [16:0] w_f1;
  logic [15:0] w_f2;

  assign w_ethertype = {r_hdr[8*12 +: 8], r_hdr[8*13 +: 8]};
  assign w_ver_ihl   = r_hdr[8*IP_OFFSET +: 8];
  assign w_ttl       = r_hdr[8*(IP_OFFSET+8) +: 8];

  // Big-endian 16-bit words of the 20-byte IPv4 header, checksum included.
  for (genvar g = 0; g < c_NUM_WORDS; g++) begin : g_words
    assign w_words[g] = {r_hdr[8*(IP_OFFSET+2*g) +: 8],
                         r_hdr[8*(IP_OFFSET+2*g+1) +: 8]};
  end

  assign w_word = w_words[r_idx];

  // Two end-around-carry folds: the first can itself carry out of bit 15.
  assign w_f1 = {1'b0, r_acc[15:0]} + {13'd0, r_acc[19:16]};
  assign w_f2 = w_f1[15:0] + {15'd0, w_f1[16]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FREE;
      r_acc    <= '0;
      r_idx    <= '0;
      r_ready  <= 1'b0;
      r_hdr_ok <= 1'b0;
      r_reason <= c_RSN_OK;
      r_hdr    <= '0;
      r_port   <= '0;
    end else begin
      case (r_state)
        S_FREE: begin
          if (bus.start_i) begin
            r_hdr    <= bus.pkt_hdr_i;
            r_port   <= bus.in_port_i;
            r_ready  <= 1'b0;
            r_hdr_ok <= 1'b0;
            r_reason <= c_RSN_OK;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_ethertype != 16'h0800) begin
            r_ready  <= 1'b1;
            r_reason <= c_RSN_NOT_IPV4;
            r_state  <= S_FREE;
          end else if (w_ver_ihl != 8'h45) begin
            r_ready  <= 1'b1;
            r_reason <= c_RSN_BAD_VIHL;
            r_state  <= S_FREE;
          end else if (w_ttl <= 8'd1) begin
            // The executor decrements TTL, so 1 would leave as 0.
            r_ready  <= 1'b1;
            r_reason <= c_RSN_TTL;
            r_state  <= S_FREE;
          end else begin
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= S_SUM;
          end
        end
        S_SUM: begin
          r_acc <= r_acc + {4'd0, w_word};
          if (r_idx == c_LAST_IDX) begin
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        S_DONE: begin
          r_ready <= 1'b1;
          if (w_f2 == 16'hFFFF) begin
            r_hdr_ok <= 1'b1;
            r_reason <= c_RSN_OK;
          end else begin
            r_hdr_ok <= 1'b0;
            r_reason <= c_RSN_BAD_CKSUM;
          end
          r_state <= S_FREE;
        end
        default: r_state <= S_FREE;
      endcase
    end
  end

  assign bus.ready_o       = r_ready;
  assign bus.busy_o        = (r_state != S_FREE);
  assign bus.pkt_hdr_o     = r_hdr;
  assign bus.in_port_o     = r_port;
  assign bus.hdr_ok_o      = r_hdr_ok;
  assign bus.drop_reason_o = r_reason;

endmodule
`default_nettype wire

// File: tb/tb_ipv4_ingress_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ipv4_ingress_checker
//  Description : Directed self-checking bench for ipv4_ingress_checker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ipv4_ingress_checker;

  localparam int HDR_MAX_LEN = 64;
  localparam int IP_OFFSET   = 14;
  localparam int NUM_PORTS   = 4;
  localparam int HW          = 8*HDR_MAX_LEN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ipv4_ingress_checker_if #(.HDR_MAX_LEN(HDR_MAX_LEN), .NUM_PORTS(NUM_PORTS)) bus ();

  ipv4_ingress_checker #(
    .HDR_MAX_LEN(HDR_MAX_LEN),
    .IP_OFFSET  (IP_OFFSET),
    .NUM_PORTS  (NUM_PORTS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ethernet header + the reference IPv4 header with selected fields replaced.
  function automatic logic [HW-1:0] frame(input logic [15:0] et, input logic [7:0] vihl,
                                          input logic [7:0] ttl, input logic [15:0] ck,
                                          input logic [7:0] fill);
    logic [7:0]    ip [20];
    logic [HW-1:0] h;
    ip = '{vihl, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, ttl, 8'h11,
           ck[15:8], ck[7:0], 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
    for (int i = 0; i < HDR_MAX_LEN; i++) h[8*i +: 8] = fill + i[7:0];
    h[8*12 +: 8] = et[15:8];
    h[8*13 +: 8] = et[7:0];
    for (int i = 0; i < 20; i++) h[8*(IP_OFFSET+i) +: 8] = ip[i];
    return h;
  endfunction

  // Presents start for one cycle; returns #1 after the accept edge.
  task automatic send(input logic [HW-1:0] hdr, input logic [NUM_PORTS-1:0] port);
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.pkt_hdr_i = hdr;
    bus.in_port_i = port;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  // Counts edges until ready_o is seen; bounded at 40.
  task automatic wait_ready(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.ready_o) break;
    end
  endtask

  task automatic verdict(input string tag, input int lat, input int exp_lat,
                         input logic exp_ok, input logic [2:0] exp_rsn,
                         input logic [HW-1:0] exp_hdr, input logic [NUM_PORTS-1:0] exp_port);
    chk({tag, "_latency"}, HW'(lat), HW'(exp_lat));
    chk({tag, "_ready"}, HW'(bus.ready_o), HW'(1'b1));
    chk({tag, "_busy"}, HW'(bus.busy_o), HW'(1'b0));
    chk({tag, "_hdr_ok"}, HW'(bus.hdr_ok_o), HW'(exp_ok));
    chk({tag, "_reason"}, HW'(bus.drop_reason_o), HW'(exp_rsn));
    chk({tag, "_pkt_hdr"}, bus.pkt_hdr_o, exp_hdr);
    chk({tag, "_in_port"}, HW'(bus.in_port_o), HW'(exp_port));
  endtask

  initial begin
    logic [HW-1:0] good, badck, ipv6, vihl46, ttl1, arp0, other;
    int n;
    logic seen;

    good   = frame(16'h0800, 8'h45, 8'h40, 16'hB861, 8'h10);
    badck  = frame(16'h0800, 8'h45, 8'h40, 16'hB862, 8'h20);
    ipv6   = frame(16'h86DD, 8'h45, 8'h40, 16'hB861, 8'h30);
    vihl46 = frame(16'h0800, 8'h46, 8'h40, 16'hB861, 8'h40);
    ttl1   = frame(16'h0800, 8'h45, 8'h01, 16'hF761, 8'h50);
    arp0   = frame(16'h0806, 8'h45, 8'h00, 16'hB861, 8'h60);
    other  = frame(16'h0800, 8'h45, 8'h40, 16'h1234, 8'h70);

    bus.start_i   = 1'b0;
    bus.pkt_hdr_i = '0;
    bus.in_port_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", HW'(bus.ready_o), HW'(1'b0));
    chk("rst_busy", HW'(bus.busy_o), HW'(1'b0));
    chk("rst_hdr_ok", HW'(bus.hdr_ok_o), HW'(1'b0));
    chk("rst_reason", HW'(bus.drop_reason_o), HW'(3'd0));
    chk("rst_pkt_hdr", bus.pkt_hdr_o, '0);
    chk("rst_in_port", HW'(bus.in_port_o), '0);

    // Valid frame
    send(good, 4'b0010);
    chk("good_busy_after_accept", HW'(bus.busy_o), HW'(1'b1));
    chk("good_ready_after_accept", HW'(bus.ready_o), HW'(1'b0));
    wait_ready(n);
    verdict("good", n, 12, 1'b1, 3'd0, good, 4'b0010);

    // Bad checksum
    send(badck, 4'b0100);
    chk("badck_ok_cleared", HW'(bus.hdr_ok_o), HW'(1'b0));
    wait_ready(n);
    verdict("badck", n, 12, 1'b0, 3'd4, badck, 4'b0100);

    // Early rejections
    send(ipv6, 4'b0001);
    wait_ready(n);
    verdict("ipv6", n, 1, 1'b0, 3'd1, ipv6, 4'b0001);
    send(vihl46, 4'b1000);
    wait_ready(n);
    verdict("vihl", n, 1, 1'b0, 3'd2, vihl46, 4'b1000);
    send(ttl1, 4'b0011);
    wait_ready(n);
    verdict("ttl1", n, 1, 1'b0, 3'd3, ttl1, 4'b0011);
    send(arp0, 4'b0101);
    wait_ready(n);
    verdict("prio", n, 1, 1'b0, 3'd1, arp0, 4'b0101);

    // Start while busy is ignored (second pulse at edge E5)
    send(good, 4'b0010);
    repeat (4) @(posedge clk);
    #1;
    bus.start_i   = 1'b1;
    bus.pkt_hdr_i = other;
    bus.in_port_i = 4'b1111;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    chk("busy_ignore_hdr", bus.pkt_hdr_o, good);
    wait_ready(n);
    verdict("busy_ignore", n + 5, 12, 1'b1, 3'd0, good, 4'b0010);

    // Start in the first ready cycle is accepted
    send(badck, 4'b0110);
    chk("rdy_start_ready_drop", HW'(bus.ready_o), HW'(1'b0));
    chk("rdy_start_busy", HW'(bus.busy_o), HW'(1'b1));
    wait_ready(n);
    verdict("rdy_start", n, 12, 1'b0, 3'd4, badck, 4'b0110);

    // Reset at edge E6 of a valid check
    send(good, 4'b0010);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_ready", HW'(bus.ready_o), HW'(1'b0));
    chk("midrst_busy", HW'(bus.busy_o), HW'(1'b0));
    chk("midrst_hdr_ok", HW'(bus.hdr_ok_o), HW'(1'b0));
    chk("midrst_reason", HW'(bus.drop_reason_o), HW'(3'd0));
    chk("midrst_pkt_hdr", bus.pkt_hdr_o, '0);
    chk("midrst_in_port", HW'(bus.in_port_o), '0);
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      seen = seen | bus.ready_o;
    end
    chk("midrst_no_ready", HW'(seen), HW'(1'b0));
    send(good, 4'b1001);
    wait_ready(n);
    verdict("post_rst", n, 12, 1'b1, 3'd0, good, 4'b1001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ipv4_ingress_checker.md
Name: ipv4_ingress_checker

Overview:
- Ingress-side counterpart to the forwarding executor; sits between the header parser and the match stage.
- Validates each received header before lookup: EtherType, IPv4 version/IHL, TTL, and the received IPv4 header checksum.
- Checksum verification is sequential, one 16-bit word per cycle.
- Passes the header and ingress port through unchanged, with a verdict and drop reason for the match/drop logic.

Parameters:
HDR_MAX_LEN, 64, header buffer length in bytes; must be >= IP_OFFSET+20
IP_OFFSET, 14, byte index of the first IPv4 header byte (after the untagged Ethernet header)
NUM_PORTS, 4, width of the port bitmap

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start_i  input  1  header valid; sampled only in FREE
pkt_hdr_i  input  8 x HDR_MAX_LEN  header bytes, index 0 = first byte on wire
in_port_i  input  NUM_PORTS  ingress port bitmap
ready_o  output  1  verdict valid (level)
busy_o  output  1  high in any state other than FREE
pkt_hdr_o  output  8 x HDR_MAX_LEN  latched copy of pkt_hdr_i
in_port_o  output  NUM_PORTS  latched copy of in_port_i
hdr_ok_o  output  1  1 = header valid for forwarding
drop_reason_o  output  3  0 OK, 1 NOT_IPV4, 2 BAD_VER_IHL, 3 TTL_EXPIRED, 4 BAD_CKSUM

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All outputs reset to 0, including every pkt_hdr_o byte. State goes to FREE, accumulator and word index clear.
- Reset mid-operation: abort with no verdict; ready_o stays 0.
- States: FREE, CHECK, SUM, DONE.
- FREE, start_i=1 at edge E0:
  - latch pkt_hdr_o <= pkt_hdr_i and in_port_o <= in_port_i;
  - clear ready_o, hdr_ok_o and drop_reason_o; set busy_o;
  - go to CHECK.
- FREE, start_i=0: hold all outputs.
- CHECK (edge E1), evaluated on the latched header. First failing check wins:
  1. bytes {12,13} != 16'h0800 -> reason 1
  2. byte IP_OFFSET != 8'h45 -> reason 2
  3. TTL byte IP_OFFSET+8 <= 1 -> reason 3, because the executor decrements TTL
  - On any failure: ready_o <= 1, hdr_ok_o <= 0, reason set, go to FREE. Latency is 1 edge after the accept edge.
  - On pass: acc <= 0, idx <= 0, go to SUM.
- SUM (edges E2..E11, 10 cycles):
  - acc <= acc + {byte[IP_OFFSET+2*idx], byte[IP_OFFSET+2*idx+1]}.
  - acc is 20 bits; maximum 10 x 0xFFFF = 0x9FFF6, no overflow.
  - idx counts 0..9; after idx=9 go to DONE.
- DONE (edge E12):
  - f1 = acc[15:0] + acc[19:16]; f2 = f1[15:0] + f1[16]. Both folds are combinational within the edge.
  - f2 == 16'hFFFF -> hdr_ok_o <= 1, reason 0; else hdr_ok_o <= 0, reason 4.
  - ready_o <= 1; go to FREE.
  - Latency is 12 edges after the accept edge.
- ready_o is a level signal. It holds 1 together with hdr_ok_o, drop_reason_o, pkt_hdr_o and in_port_o until the next accepted start_i.
- start_i in the same cycle that ready_o is high while in FREE is accepted; outputs clear at that edge.
- start_i while busy is ignored: no queueing, and the latched data does not change.
- The checksum field (bytes IP_OFFSET+10, +11) is included in the sum, not zeroed. Sum value 0x0000 after folding is a failure.
- Options (IHL != 5) are unsupported and rejected as reason 2.
- The block never modifies header bytes.

Test Plan:
- Valid frame: bytes 12-13 = 08 00; IPv4 bytes 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7; start 1 cycle -> busy_o=1, ready_o=1 exactly 12 edges later, hdr_ok_o=1, reason 0, pkt_hdr_o equals input, in_port_o=4'b0010 echoed.
- Same frame with checksum bytes changed to B8 62 -> ready at 12 edges, hdr_ok_o=0, reason 4.
- EtherType 0x86DD -> ready after 1 edge, reason 1. Same frame with byte 14 = 0x46 -> reason 2. Same frame with TTL = 0x01 (checksum otherwise correct) -> reason 3.
- Priority: EtherType 0x0806 plus TTL 0 -> reason 1 only, ready after 1 edge.
- Second start_i pulse with a different header at edge E5 of a busy check -> ignored: verdict and pkt_hdr_o reflect the first frame. A start_i in the first ready cycle is accepted: ready_o drops and the new verdict appears 12 edges later.
- rst asserted at edge E6 of a valid check -> all outputs 0 next cycle; no ready_o. After rst release, a new valid frame completes normally with hdr_ok_o=1.
